// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: state encoding and framing constants.
// Define UART_RX_PARITY_EN to add the even-parity bit between data and stop.
package uart_pkg;

    localparam int DATA_BITS           = 8;
    localparam int MIN_CLOCKS_PER_BAUD = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP,
        ST_HOLD,
        ST_WAIT_IDLE
    } rx_state_e;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx_async,
    output logic rx_sync
);

    logic meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q  <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            meta_q  <= rx_async;
            rx_sync <= meta_q;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1 by default; define UART_RX_PARITY_EN for 8E1 framing.
// Holds each received byte until the downstream consumer acknowledges it.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int ClocksPerBaud = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_in,
    output logic [7:0] rx_byte_out,
    output logic       rx_byte_valid_out,
    input  logic       rx_byte_done_in,
    output logic       clear_to_send_out_n,
    output logic       rx_error_out
);

    localparam int CntW    = $clog2(ClocksPerBaud);
    localparam int BitIdxW = $clog2(DATA_BITS);

    localparam logic [CntW-1:0]    HalfReload = CntW'(ClocksPerBaud / 2 - 1);
    localparam logic [CntW-1:0]    FullReload = CntW'(ClocksPerBaud - 1);
    localparam logic [BitIdxW-1:0] LastBit    = BitIdxW'(DATA_BITS - 1);

    if (ClocksPerBaud < MIN_CLOCKS_PER_BAUD || (ClocksPerBaud % 2) != 0) begin : g_bad_cfg
        $error("uart_receiver: ClocksPerBaud must be even and >= %0d", MIN_CLOCKS_PER_BAUD);
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the data bits plus the parity bit must hold an even number of ones.
    function automatic logic parity_err(input logic [DATA_BITS-1:0] data, input logic par_bit);
        return ^{data, par_bit};
    endfunction
`endif

    rx_state_e              state_q, state_d;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BitIdxW-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic [DATA_BITS-1:0]   byte_q;
    logic                   err_q, err_d;
    logic                   load_byte;
    logic                   rx_s;

    uart_rx_sync u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .rx_async (rx_in),
        .rx_sync  (rx_s)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        err_d     = 1'b0;
        load_byte = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = HalfReload;
                end
            end

            // Half a bit period in: a line that is high again was only a glitch.
            ST_START: begin
                if (cnt_q == '0) begin
                    if (!rx_s) begin
                        state_d   = ST_DATA;
                        cnt_d     = FullReload;
                        bit_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FullReload;
                    if (bit_idx_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (cnt_q == '0) begin
                    if (parity_err(shift_q, rx_s)) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end else begin
                        state_d = ST_STOP;
                        cnt_d   = FullReload;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif

            ST_STOP: begin
                if (cnt_q == '0) begin
                    if (rx_s) begin
                        load_byte = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            // Line activity is deliberately ignored while the byte is unclaimed.
            ST_HOLD: begin
                if (rx_byte_done_in) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            byte_q    <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            err_q     <= err_d;
            if (load_byte) begin
                byte_q <= shift_q;
            end
        end
    end

    // The shift register is pure data and is always overwritten before it is used.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign rx_byte_out         = byte_q;
    assign rx_byte_valid_out   = (state_q == ST_HOLD);
    assign clear_to_send_out_n = (state_q != ST_IDLE);
    assign rx_error_out        = err_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver (ClocksPerBaud=8, clk period 2 ticks).
`timescale 1ns/1ps
module tb_uart_receiver;

    localparam int ClocksPerBaud = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_in = 1'b1;
    logic       rx_byte_done_in = 1'b0;
    logic [7:0] rx_byte_out;
    logic       rx_byte_valid_out;
    logic       clear_to_send_out_n;
    logic       rx_error_out;

    int n_checks = 0;
    int n_errors = 0;

    int valid_cnt   = 0;
    int err_cnt     = 0;
    int byte_glitch = 0;
    int cts_gap     = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] prev_byte  = 8'h00;

`ifdef UART_RX_PARITY_EN
    logic flip_parity = 1'b0;
`endif

    uart_receiver #(.ClocksPerBaud(ClocksPerBaud)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .rx_in               (rx_in),
        .rx_byte_out         (rx_byte_out),
        .rx_byte_valid_out   (rx_byte_valid_out),
        .rx_byte_done_in     (rx_byte_done_in),
        .clear_to_send_out_n (clear_to_send_out_n),
        .rx_error_out        (rx_error_out)
    );

    always #1 clk = ~clk;

    // Output monitor, sampled half a tick after each rising edge.
    always @(posedge clk) begin
        #0.5;
        if (rx_byte_valid_out) valid_cnt++;
        if (rx_error_out) err_cnt++;
        if (rx_byte_valid_out && prev_valid && rx_byte_out !== prev_byte) byte_glitch++;
        prev_valid = rx_byte_valid_out;
        prev_byte  = rx_byte_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        valid_cnt   = 0;
        err_cnt     = 0;
        byte_glitch = 0;
        cts_gap     = 0;
    endtask

    // Drives one bit period; counts cycles where cts_n is low from sample index cts_from on.
    task automatic drive_bit(input logic b, input int cts_from);
        rx_in = b;
        for (int i = 0; i < ClocksPerBaud; i++) begin
            @(negedge clk);
            if (i >= cts_from && clear_to_send_out_n == 1'b0) cts_gap++;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0, 3);
        for (int i = 0; i < 8; i++) drive_bit(b[i], 0);
`ifdef UART_RX_PARITY_EN
        drive_bit((^b) ^ flip_parity, 0);
`endif
        drive_bit(stop, ClocksPerBaud);
        rx_in = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_byte", {24'h0, rx_byte_out}, 32'h00);
        check("rst_valid", {31'h0, rx_byte_valid_out}, 32'h0);
        check("rst_err", {31'h0, rx_error_out}, 32'h0);
        check("rst_cts_n", {31'h0, clear_to_send_out_n}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // 0x55 with immediate acknowledge
        rx_byte_done_in = 1'b1;
        clear_mon();
        send_frame(8'h55, 1'b1);
        check("t1_byte", {24'h0, rx_byte_out}, 32'h55);
        check("t1_valid_cycles", valid_cnt, 1);
        check("t1_errors", err_cnt, 0);
        check("t1_cts_low_in_frame", cts_gap, 0);
        check("t1_cts_n_idle", {31'h0, clear_to_send_out_n}, 32'h0);

        // 0xAA held, second frame ignored while holding
        rx_byte_done_in = 1'b0;
        clear_mon();
        send_frame(8'hAA, 1'b1);
        repeat (20) @(negedge clk);
        check("t2_valid_held", {31'h0, rx_byte_valid_out}, 32'h1);
        check("t2_byte_held", {24'h0, rx_byte_out}, 32'hAA);
        send_frame(8'h33, 1'b1);
        check("t2_valid_after_2nd", {31'h0, rx_byte_valid_out}, 32'h1);
        check("t2_byte_after_2nd", {24'h0, rx_byte_out}, 32'hAA);
        check("t2_cts_n_hold", {31'h0, clear_to_send_out_n}, 32'h1);
        check("t2_errors", err_cnt, 0);
        check("t2_byte_glitch", byte_glitch, 0);
        rx_byte_done_in = 1'b1;
        @(negedge clk);
        check("t2_valid_after_done", {31'h0, rx_byte_valid_out}, 32'h0);
        check("t2_cts_n_after_done", {31'h0, clear_to_send_out_n}, 32'h0);

        // Start-bit glitch
        repeat (4) @(negedge clk);
        clear_mon();
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        check("t3_cts_n_in_start", {31'h0, clear_to_send_out_n}, 32'h1);
        repeat (10) @(negedge clk);
        check("t3_valid_cycles", valid_cnt, 0);
        check("t3_errors", err_cnt, 0);
        check("t3_cts_n_idle", {31'h0, clear_to_send_out_n}, 32'h0);

        // Framing error then a good frame
        clear_mon();
        send_frame(8'h3C, 1'b0);
        check("t4_error_cycles", err_cnt, 1);
        check("t4_valid_cycles", valid_cnt, 0);
        check("t4_byte_unchanged", {24'h0, rx_byte_out}, 32'hAA);
        check("t4_cts_n_idle", {31'h0, clear_to_send_out_n}, 32'h0);
        clear_mon();
        send_frame(8'h12, 1'b1);
        check("t4_good_byte", {24'h0, rx_byte_out}, 32'h12);
        check("t4_good_valid_cycles", valid_cnt, 1);
        check("t4_good_errors", err_cnt, 0);

        // Reset mid-frame (start + two data bits of 0x5A)
        clear_mon();
        drive_bit(1'b0, 3);
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        check("t5_cts_n_mid_data", {31'h0, clear_to_send_out_n}, 32'h1);
        rst_n = 1'b0;
        #0.5;
        check("t5_rst_byte", {24'h0, rx_byte_out}, 32'h00);
        check("t5_rst_valid", {31'h0, rx_byte_valid_out}, 32'h0);
        check("t5_rst_err", {31'h0, rx_error_out}, 32'h0);
        check("t5_rst_cts_n", {31'h0, clear_to_send_out_n}, 32'h0);
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("t5_no_err_pulse", err_cnt, 0);
        clear_mon();
        send_frame(8'h81, 1'b1);
        check("t5_byte", {24'h0, rx_byte_out}, 32'h81);
        check("t5_valid_cycles", valid_cnt, 1);
        check("t5_errors", err_cnt, 0);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones, so the correct even-parity bit is 1
        clear_mon();
        flip_parity = 1'b0;
        send_frame(8'h07, 1'b1);
        check("t6_byte", {24'h0, rx_byte_out}, 32'h07);
        check("t6_valid_cycles", valid_cnt, 1);
        check("t6_errors", err_cnt, 0);
        clear_mon();
        flip_parity = 1'b1;
        send_frame(8'h07, 1'b1);
        check("t6_bad_error_cycles", err_cnt, 1);
        check("t6_bad_valid_cycles", valid_cnt, 0);
        flip_parity = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter ClocksPerBaud, default 8, gives clk cycles per UART bit period; legal values are >=4 and even.
REQ-002 clk  input  1  sole clock; all state changes occur on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset; asserting it forces reset state immediately, and deassertion is synchronous to clk.
REQ-004 rx_in  input  1  asynchronous serial line, idle high, 8N1 framing (8E1 with parity feature).
REQ-005 rx_byte_out  output  8  received byte, LSB first on the wire, stable while rx_byte_valid_out=1.
REQ-006 rx_byte_valid_out  output  1  byte held and available to downstream deserializer.
REQ-007 rx_byte_done_in  input  1  downstream consumed byte; sampled only when rx_byte_valid_out=1.
REQ-008 clear_to_send_out_n  output  1  active-low; 0 only when receiver is idle and may accept a new frame.
REQ-009 rx_error_out  output  1  one-cycle pulse on framing (or parity) error.

Function
REQ-010 rx_in SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all timing below is relative to the synchronized signal rx_s.
REQ-011 State machine states SHALL be IDLE, START, DATA, PARITY (feature only), STOP, HOLD, WAIT_IDLE.
REQ-012 IDLE: on rx_s=0, go to START and load the bit counter with ClocksPerBaud/2-1.
REQ-013 START: when the counter reaches 0, re-sample rx_s; if 0, go to DATA with counter ClocksPerBaud-1; if 1 (glitch), return to IDLE with no error.
REQ-014 DATA: sample rx_s at each counter expiry, shift into bit 7 of the shift register (LSB first), reload counter, and after 8 samples go to PARITY or STOP.
REQ-015 STOP: at counter expiry, rx_s=1 loads rx_byte_out and goes to HOLD; rx_s=0 pulses rx_error_out, discards the byte, and goes to WAIT_IDLE.
REQ-016 HOLD: rx_byte_valid_out=1; on rx_byte_done_in=1, go to IDLE next cycle with rx_byte_valid_out=0 in that cycle.
REQ-017 The first cycle of HOLD with rx_byte_done_in=1 is a legal handshake, giving one cycle of valid.
REQ-018 In HOLD, rx_s activity SHALL be ignored (no new frame, no error); a frame sent while holding is lost.
REQ-019 WAIT_IDLE: remain until rx_s=1, then go to IDLE.
REQ-020 clear_to_send_out_n SHALL be 0 iff state==IDLE, and 1 in all other states.
REQ-021 rx_byte_out SHALL change only on entry to HOLD.
REQ-022 rx_error_out SHALL be registered and high for exactly one cycle per error.
REQ-023 Bit counter width SHALL be $clog2(ClocksPerBaud); no wrap-around beyond reload values.

Reset
REQ-024 While rst_n=0: state=IDLE, rx_byte_out=8'h00, rx_byte_valid_out=0, rx_error_out=0, clear_to_send_out_n=0, synchronizer flops=1, counters=0.
REQ-025 Reset asserted mid-frame or in HOLD SHALL discard the frame or byte without an error pulse.

Configuration
REQ-026 With macro UART_RX_PARITY_EN defined, PARITY state follows DATA: sample one bit; even parity over data+bit mismatch pulses rx_error_out and goes to WAIT_IDLE, else STOP.
REQ-027 Without UART_RX_PARITY_EN, the PARITY state and logic SHALL be absent and the frame is 10 bits.

Structure
REQ-028 Package uart_pkg SHALL hold the state encoding, the data-bit count (8), and the minimum ClocksPerBaud constant.
REQ-029 The synchronizer SHALL be a separate sub-module named uart_rx_sync (2-flop, parameterless).

Verification (ClocksPerBaud=8, clk period 2 ticks)
REQ-030 Send 0x55 8N1, done held 1 -> rx_byte_out=0x55, valid for exactly 1 cycle, cts_n=1 from start bit until return to IDLE.
REQ-031 Send 0xAA, done held 0 for 20 cycles, then pulse 1 -> valid stays 1 with byte 0xAA throughout; a second frame sent meanwhile is ignored; cts_n returns to 0 after done.
REQ-032 rx_in low 2 cycles then high (glitch) -> no valid, no error, back to IDLE, cts_n=0.
REQ-033 Frame 0x3C with stop bit 0 -> one-cycle rx_error_out, no valid; the following good frame 0x12 is received correctly.
REQ-034 rst_n pulsed low mid-DATA -> all outputs at reset values immediately; the next frame 0x81 is received correctly.
REQ-035 With UART_RX_PARITY_EN: 0x07 with parity 1 -> byte received; with parity 0 -> rx_error_out pulse and no valid.
